bist_vector_gen: RTL and testbench
==================================

Name: bist_vector_gen

Overview:
- Sequential stimulus/response stage that sits around the 4-input combinational logic under test (inputs a,b,c,d; output y).
- Upstream role: drives a,b,c,d with an exhaustive or pseudo-random vector sequence, holding each vector for a programmable number of cycles.
- Downstream role: samples y once per vector and compresses the results into a shift signature and a ones count.
- Gives hardware self-test in place of hand-written vector lists.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is held; legal range 1..255.
- SEED, 4'b0001, LFSR start state; 4'b0000 is replaced by 4'b0001.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- mode  input  1  0 = exhaustive count, 1 = LFSR; captured on start.
- a  output  1  vector bit 3.
- b  output  1  vector bit 2.
- c  output  1  vector bit 1.
- d  output  1  vector bit 0.
- y  input  1  response from the logic under test.
- busy  output  1  high while vectors are being applied.
- done  output  1  high from run completion until the next accepted start or reset.
- signature  output  16  response shift register.
- ones_count  output  5  number of vectors that returned y=1.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - a, b, c, d, busy, done = 0; signature = 16'h0000; ones_count = 0.
  - Reset mid-run aborts immediately; no partial result is retained.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at edge k: capture mode, clear signature and ones_count, clear done, load the first vector, enter DRIVE.
  - busy=1 from edge k.
- DRIVE:
  - Hold counter runs 0..HOLD_CYCLES-1 for each vector.
  - On the edge where the counter equals HOLD_CYCLES-1: signature <= {signature[14:0], y}; ones_count += y; advance to the next vector; reset the counter.
  - y is sampled only on that edge, which allows HOLD_CYCLES-1 cycles of settling.
- Exhaustive mode: N = 16 vectors, {a,b,c,d} = 0,1,...,15.
- LFSR mode:
  - N = 15 vectors, starting at SEED (0000 forced to 0001).
  - next = {s[2:0], s[3]^s[2]} (x^4+x^3+1, maximal length).
  - Sequence from 0001: 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8.
- Completion:
  - After the sample of vector N-1, enter DONE at edge k + N*HOLD_CYCLES.
  - In DONE: busy=0, done=1, a..d = 0; signature and ones_count frozen.
- DONE + start=1: acts as in IDLE (new run, done drops at that edge).
- start while busy: ignored; mode changes mid-run are ignored.
- Width rules:
  - ones_count saturates at 16 (never wraps).
  - In LFSR mode signature[15] stays 0.
- HOLD_CYCLES=1: a new vector every cycle; y is sampled on the same edge the vector changes, with no settle margin. Legal.
- rst has priority over start at the same edge.

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, DRIVE, DONE}.
  - constants VEC_W=4, SIG_W=16, N_EXH=16, N_LFSR=15.
  - LFSR tap function.
- One sub-module: bist_lfsr4 (4-bit LFSR with load/enable), instantiated once.
- Hold counter, FSM and response compaction stay in the top level.

Test Plan:
- Exhaustive parity: HOLD_CYCLES=2, y=a^b^c^d, pulse start -> done at start edge + 32 cycles; signature=16'h6996, ones_count=8.
- Exhaustive MSB: y=a -> signature=16'h00FF, ones_count=8.
- Vector pacing: HOLD_CYCLES=10 -> each vector on a..d for exactly 10 cycles in order 0..15.
- LFSR mode: y=d, SEED=1 -> vectors 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8; signature=16'h4D78, ones_count=8; done after 15*HOLD_CYCLES cycles.
- Saturation: exhaustive mode with y tied 1 -> ones_count=16, signature=16'hFFFF.
- Control corners:
  - start pulsed while busy -> no restart, same final signature.
  - rst at cycle 7 of a run -> all outputs 0 next cycle, state IDLE.
  - start in DONE -> done drops and a new run begins.
  - SEED=0 -> sequence begins at 0001.

Source files
------------

// File: rtl/bist_vector_gen_pkg.sv
// Shared types, sizes and LFSR step function for the BIST vector generator.
package bist_pkg;
  localparam int VEC_W  = 4;
  localparam int SIG_W  = 16;
  localparam int N_EXH  = 16;
  localparam int N_LFSR = 15;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  // x^4 + x^3 + 1, maximal length over the 15 non-zero states
  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction
endpackage

// File: rtl/bist_vector_gen_if.sv
// Stimulus/response bundle between the generator and its logic under test.
interface bist_vector_gen_if;
  import bist_pkg::*;

  logic             start;
  logic             mode;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             y;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [4:0]       ones_count;

  modport master (
    output start, mode, y,
    input  a, b, c, d, busy, done, signature, ones_count
  );

  modport slave (
    input  start, mode, y,
    output a, b, c, d, busy, done, signature, ones_count
  );
endinterface

// File: rtl/bist_vector_gen_lfsr4.sv
// 4-bit Fibonacci LFSR with synchronous load and step enable.
module bist_lfsr4
  import bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [VEC_W-1:0] load_val,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= load_val;
    else if (en)   q <= lfsr_next(q);
  end
endmodule

// File: rtl/bist_vector_gen.sv
// BIST stage: applies exhaustive or LFSR vectors to a 4-input block and
// compacts its response into a shift signature and a saturating ones count.
module bist_vector_gen
  import bist_pkg::*;
#(
  parameter int unsigned     HOLD_CYCLES = 10,
  parameter logic [VEC_W-1:0] SEED       = 4'b0001
)(
  input  logic             clk,
  input  logic             rst,
  bist_vector_gen_if.slave bus
);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] SEED_EFF  = (SEED == '0) ? 4'b0001 : SEED;

  state_t           state;
  logic             mode_r;
  logic             busy_r;
  logic             done_r;
  logic [7:0]       hold_cnt;
  logic [VEC_W-1:0] vec_idx;
  logic [SIG_W-1:0] sig_r;
  logic [4:0]       ones_r;
  logic [VEC_W-1:0] lfsr_q;
  logic [VEC_W-1:0] cur_vec;
  logic             accept;
  logic             sample;
  logic             last;

  assign accept = (state != DRIVE) && bus.start;
  assign sample = (state == DRIVE) && (hold_cnt == HOLD_LAST);
  assign last   = vec_idx == (mode_r ? 4'(N_LFSR - 1) : 4'(N_EXH - 1));

  bist_lfsr4 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (sample && mode_r),
    .load_val (SEED_EFF),
    .q        (lfsr_q)
  );

  // Exhaustive mode reuses the vector index as the vector itself
  assign cur_vec = mode_r ? lfsr_q : vec_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hold_cnt <= '0;
      vec_idx  <= '0;
      sig_r    <= '0;
      ones_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= DRIVE;
            mode_r   <= bus.mode;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            hold_cnt <= '0;
            vec_idx  <= '0;
            sig_r    <= '0;
            ones_r   <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            hold_cnt <= '0;
            sig_r    <= {sig_r[SIG_W-2:0], bus.y};
            ones_r   <= (ones_r == 5'd16) ? ones_r : ones_r + 5'(bus.y);
            if (last) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              vec_idx <= vec_idx + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = cur_vec & {VEC_W{busy_r}};
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.signature  = sig_r;
  assign bus.ones_count = ones_r;
endmodule

// File: tb/tb_bist_vector_gen.sv
// Directed bench: four generator instances with different hold/seed settings,
// each closed around a selectable model of the logic under test.
module tb_bist_vector_gen;
  import bist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_i [4];
  logic        mode_i  [4];
  int          ysel    [4];
  logic [3:0]  vec_o   [4];
  logic        busy_o  [4];
  logic        done_o  [4];
  logic [15:0] sig_o   [4];
  logic [4:0]  ones_o  [4];
  logic [3:0]  lfsr_seq [15];

  typedef struct {
    int          inst;
    logic        m;
    int          ysel;
    int          hold;
    int          n;
    logic [15:0] sig;
    int          ones;
    bit          chkv;
    int          poke;
  } run_t;

  run_t tbl [13];

  function automatic logic ymap(input int s, input logic [3:0] v);
    case (s)
      0:       return ^v;
      1:       return v[3];
      2:       return v[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] exp_vec(input logic m, input int idx);
    if (m) return lfsr_seq[idx];
    return 4'(idx);
  endfunction

  bist_vector_gen_if bus0 ();
  bist_vector_gen_if bus1 ();
  bist_vector_gen_if bus2 ();
  bist_vector_gen_if bus3 ();

  bist_vector_gen #(.HOLD_CYCLES(2),  .SEED(4'b0001)) u_h2  (.clk(clk), .rst(rst), .bus(bus0));
  bist_vector_gen #(.HOLD_CYCLES(10), .SEED(4'b0001)) u_h10 (.clk(clk), .rst(rst), .bus(bus1));
  bist_vector_gen #(.HOLD_CYCLES(1),  .SEED(4'b0001)) u_h1  (.clk(clk), .rst(rst), .bus(bus2));
  bist_vector_gen #(.HOLD_CYCLES(3),  .SEED(4'b0000)) u_s0  (.clk(clk), .rst(rst), .bus(bus3));

  assign bus0.start = start_i[0];
  assign bus0.mode  = mode_i[0];
  assign bus0.y     = ymap(ysel[0], vec_o[0]);
  assign vec_o[0]   = {bus0.a, bus0.b, bus0.c, bus0.d};
  assign busy_o[0]  = bus0.busy;
  assign done_o[0]  = bus0.done;
  assign sig_o[0]   = bus0.signature;
  assign ones_o[0]  = bus0.ones_count;

  assign bus1.start = start_i[1];
  assign bus1.mode  = mode_i[1];
  assign bus1.y     = ymap(ysel[1], vec_o[1]);
  assign vec_o[1]   = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign busy_o[1]  = bus1.busy;
  assign done_o[1]  = bus1.done;
  assign sig_o[1]   = bus1.signature;
  assign ones_o[1]  = bus1.ones_count;

  assign bus2.start = start_i[2];
  assign bus2.mode  = mode_i[2];
  assign bus2.y     = ymap(ysel[2], vec_o[2]);
  assign vec_o[2]   = {bus2.a, bus2.b, bus2.c, bus2.d};
  assign busy_o[2]  = bus2.busy;
  assign done_o[2]  = bus2.done;
  assign sig_o[2]   = bus2.signature;
  assign ones_o[2]  = bus2.ones_count;

  assign bus3.start = start_i[3];
  assign bus3.mode  = mode_i[3];
  assign bus3.y     = ymap(ysel[3], vec_o[3]);
  assign vec_o[3]   = {bus3.a, bus3.b, bus3.c, bus3.d};
  assign busy_o[3]  = bus3.busy;
  assign done_o[3]  = bus3.done;
  assign sig_o[3]   = bus3.signature;
  assign ones_o[3]  = bus3.ones_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int k);
    chk({tag, "_busy"}, 32'(busy_o[k]), 32'd0);
    chk({tag, "_done"}, 32'(done_o[k]), 32'd0);
    chk({tag, "_vec"},  32'(vec_o[k]),  32'd0);
    chk({tag, "_sig"},  32'(sig_o[k]),  32'd0);
    chk({tag, "_ones"}, 32'(ones_o[k]), 32'd0);
  endtask

  // Entered at a negedge; returns at a negedge.
  task automatic do_run(input run_t r, input int id);
    int j;
    bit fin;
    int k;
    k = r.inst;
    ysel[k]    = r.ysel;
    mode_i[k]  = r.m;
    start_i[k] = 1'b1;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
    chk($sformatf("r%0d_busy_at_start", id), 32'(busy_o[k]), 32'd1);
    chk($sformatf("r%0d_done_at_start", id), 32'(done_o[k]), 32'd0);
    chk($sformatf("r%0d_first_vec", id), 32'(vec_o[k]), 32'(exp_vec(r.m, 0)));
    j = 0;
    fin = 1'b0;
    while (!fin && j < r.n * r.hold + 20) begin
      if (r.poke > 0 && j == r.poke) begin
        start_i[k] = 1'b1;
        mode_i[k]  = ~r.m;
      end
      @(posedge clk); #1;
      j++;
      start_i[k] = 1'b0;
      mode_i[k]  = r.m;
      if (done_o[k]) fin = 1'b1;
      else if (r.chkv && (j / r.hold) < r.n)
        chk($sformatf("r%0d_vec_c%0d", id, j), 32'(vec_o[k]), 32'(exp_vec(r.m, j / r.hold)));
    end
    chk($sformatf("r%0d_done_seen", id), 32'(fin), 32'd1);
    chk($sformatf("r%0d_run_len", id), 32'(j), 32'(r.n * r.hold));
    chk($sformatf("r%0d_signature", id), 32'(sig_o[k]), 32'(r.sig));
    chk($sformatf("r%0d_ones", id), 32'(ones_o[k]), 32'(r.ones));
    chk($sformatf("r%0d_busy_end", id), 32'(busy_o[k]), 32'd0);
    chk($sformatf("r%0d_vec_end", id), 32'(vec_o[k]), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    lfsr_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    //             inst m     ysel hold n   sig       ones chkv poke
    tbl[0]  = '{0, 1'b0, 0, 2,  16, 16'h6996, 8,  1'b1, 0};
    tbl[1]  = '{0, 1'b0, 1, 2,  16, 16'h00FF, 8,  1'b0, 0};
    tbl[2]  = '{0, 1'b0, 3, 2,  16, 16'hFFFF, 16, 1'b0, 0};
    tbl[3]  = '{0, 1'b0, 2, 2,  16, 16'h5555, 8,  1'b0, 0};
    tbl[4]  = '{0, 1'b1, 2, 2,  15, 16'h4D78, 8,  1'b1, 0};
    tbl[5]  = '{0, 1'b1, 3, 2,  15, 16'h7FFF, 15, 1'b0, 0};
    tbl[6]  = '{0, 1'b1, 1, 2,  15, 16'h09AF, 8,  1'b0, 0};
    tbl[7]  = '{0, 1'b0, 0, 2,  16, 16'h6996, 8,  1'b1, 5};
    tbl[8]  = '{1, 1'b0, 0, 10, 16, 16'h6996, 8,  1'b1, 0};
    tbl[9]  = '{1, 1'b1, 2, 10, 15, 16'h4D78, 8,  1'b1, 0};
    tbl[10] = '{2, 1'b0, 0, 1,  16, 16'h6996, 8,  1'b1, 0};
    tbl[11] = '{2, 1'b1, 2, 1,  15, 16'h4D78, 8,  1'b1, 0};
    tbl[12] = '{3, 1'b1, 2, 3,  15, 16'h4D78, 8,  1'b1, 0};

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_i[k] = 1'b0;
      mode_i[k]  = 1'b0;
      ysel[k]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_idle($sformatf("reset_i%0d", k), k);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) do_run(tbl[i], i);

    // Reset seven cycles into a run clears everything and stays idle
    ysel[0]    = 0;
    mode_i[0]  = 1'b0;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrun_sig_before_rst", 32'(sig_o[0]), 32'h3);
    chk("midrun_ones_before_rst", 32'(ones_o[0]), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrun_rst", 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("post_rst_done", 32'(done_o[0]), 32'd0);

    // Reset wins over a coincident start
    @(negedge clk);
    rst        = 1'b1;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    start_i[0] = 1'b0;
    chk("rst_prio_busy", 32'(busy_o[0]), 32'd0);
    @(posedge clk); #1;
    chk("rst_prio_still_idle", 32'(busy_o[0]), 32'd0);
    @(negedge clk);

    // Recovery run after the resets
    do_run(tbl[0], 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
